// File: rtl/vga_if.sv
// vga_if: raster timing bundle from vga_sync_gen to the renderer / VGA pins.
//   hsync, vsync  : sync pulses (polarity set by the generator parameters)
//   active        : 1 inside the visible window
//   x, y          : pixel position that active/hsync/vsync describe
//   line_start    : 1-cycle pulse at x==0
//   frame_start   : 1-cycle pulse at x==0 && y==0
// master = timing generator, slave = consumer.
interface vga_if;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [10:0] x;
    logic [9:0]  y;
    logic        line_start;
    logic        frame_start;

    modport master (
        output hsync, vsync, active, x, y, line_start, frame_start
    );
    modport slave (
        input  hsync, vsync, active, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing controller on the pixel clock.
// Waits for PLL lock (2-flop synchronised), then runs horizontal/vertical
// counters and decodes sync, active window, position and strobes.
// Ports:
//   px_clk      in   pixel clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   pll_locked  in   PLL lock, asynchronous to px_clk
//   vga         vga_if.master  registered timing outputs
//
// state     | meaning
// ----------+-------------------------------------------------------
// WAIT_LOCK | counters held at 0, outputs inactive, waiting on lock_s
// RUN       | raster counters running, outputs decoded from hc/vc
module vga_sync_gen #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1
) (
    input  logic  px_clk,
    input  logic  rst_n,
    input  logic  pll_locked,
    vga_if.master vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_VIS + V_FP + V_SYNC);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] hc, hc_nxt;
    logic [9:0]  vc, vc_nxt;
    logic        lock_m, lock_s;

    logic        hsync_d, vsync_d, active_d, ls_d, fs_d;
    logic [10:0] x_d;
    logic [9:0]  y_d;
    logic        hsync_q, vsync_q, active_q, ls_q, fs_q;
    logic [10:0] x_q;
    logic [9:0]  y_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            hc    <= '0;
            vc    <= '0;
        end else begin
            state <= state_nxt;
            hc    <= hc_nxt;
            vc    <= vc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        vc_nxt    = vc;
        case (state)
            WAIT_LOCK: begin
                hc_nxt = '0;
                vc_nxt = '0;
                if (lock_s) state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    // lost lock: abandon the frame, restart from frame_start on re-lock
                    state_nxt = WAIT_LOCK;
                    hc_nxt    = '0;
                    vc_nxt    = '0;
                end else if (hc == H_LAST) begin
                    hc_nxt = '0;
                    vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
                end else begin
                    hc_nxt = hc + 11'd1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                hc_nxt    = '0;
                vc_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        hsync_d  = ~H_POL;
        vsync_d  = ~V_POL;
        active_d = 1'b0;
        x_d      = '0;
        y_d      = '0;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (state == RUN) begin
            hsync_d  = (hc >= HS_BEG && hc < HS_END) ? H_POL : ~H_POL;
            vsync_d  = (vc >= VS_BEG && vc < VS_END) ? V_POL : ~V_POL;
            active_d = (hc < H_ACT) && (vc < V_ACT);
            x_d      = hc;
            y_d      = vc;
            ls_d     = (hc == 11'd0);
            fs_d     = (hc == 11'd0) && (vc == 10'd0);
        end
    end

    // One register stage for every output keeps them mutually aligned.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.active      = active_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: a reduced-timing instance (whole frames) and a
// default 800x600 instance (line-level timing), checked against a reference
// model feeding a scoreboard plus per-scenario inline checks.
module tb_vga_sync_gen;

    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHV + SHF + SHS + SHB;   // 15
    localparam int SVT = SVV + SVF + SVS + SVB;   // 8
    localparam int DHV = 800, DHF = 56, DHS = 120, DHB = 64;
    localparam int DVV = 600, DVF = 37, DVS = 6, DVB = 23;
    localparam int DHT = DHV + DHF + DHS + DHB;   // 1040
    localparam int DVT = DVV + DVF + DVS + DVB;   // 666

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
    } vout_t;

    logic px_clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    vga_if vs ();
    vga_if vd ();

    vga_sync_gen #(
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_s (
        .px_clk(px_clk), .rst_n(rst_n), .pll_locked(pll_locked), .vga(vs)
    );

    vga_sync_gen dut_d (
        .px_clk(px_clk), .rst_n(rst_n), .pll_locked(pll_locked), .vga(vd)
    );

    always #5 px_clk = ~px_clk;

    function automatic vout_t decode(bit run, int h, int v, int hv, int hf, int hsn,
                                     int vv, int vf, int vsn);
        vout_t o;
        o = '0;
        if (run) begin
            o.hs  = (h >= hv + hf) && (h < hv + hf + hsn);
            o.vs  = (v >= vv + vf) && (v < vv + vf + vsn);
            o.act = (h < hv) && (v < vv);
            o.x   = 11'(h);
            o.y   = 10'(v);
            o.ls  = (h == 0);
            o.fs  = (h == 0) && (v == 0);
        end
        return o;
    endfunction

    // reference model: expected output of each edge pushed at that edge
    vout_t sbq_s[$];
    vout_t sbq_d[$];
    bit m_l1, m_l2, m_run;
    int m_hs, m_vs, m_hd, m_vd;

    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_l1 <= 1'b0; m_l2 <= 1'b0; m_run <= 1'b0;
            m_hs <= 0; m_vs <= 0; m_hd <= 0; m_vd <= 0;
            sbq_s.delete();
            sbq_d.delete();
        end else begin
            sbq_s.push_back(decode(m_run, m_hs, m_vs, SHV, SHF, SHS, SVV, SVF, SVS));
            sbq_d.push_back(decode(m_run, m_hd, m_vd, DHV, DHF, DHS, DVV, DVF, DVS));
            m_l1 <= pll_locked;
            m_l2 <= m_l1;
            if (!m_run || !m_l2) begin
                m_run <= m_run ? 1'b0 : m_l2;
                m_hs <= 0; m_vs <= 0; m_hd <= 0; m_vd <= 0;
            end else begin
                if (m_hs == SHT - 1) begin
                    m_hs <= 0;
                    m_vs <= (m_vs == SVT - 1) ? 0 : m_vs + 1;
                end else m_hs <= m_hs + 1;
                if (m_hd == DHT - 1) begin
                    m_hd <= 0;
                    m_vd <= (m_vd == DVT - 1) ? 0 : m_vd + 1;
                end else m_hd <= m_hd + 1;
            end
        end
    end

    always @(negedge px_clk) begin
        vout_t e, a;
        if (rst_n && sbq_s.size() > 0) begin
            e = sbq_s.pop_front();
            a = {vs.hsync, vs.vsync, vs.active, vs.x, vs.y, vs.line_start, vs.frame_start};
            n_vec++;
            if (a !== e) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_small t=%0t got=%h expected=%h", $time, a, e);
            end
        end
        if (rst_n && sbq_d.size() > 0) begin
            e = sbq_d.pop_front();
            a = {vd.hsync, vd.vsync, vd.active, vd.x, vd.y, vd.line_start, vd.frame_start};
            n_vec++;
            if (a !== e) begin
                n_err++;
                if (n_err < 20) $display("FAIL sb_default t=%0t got=%h expected=%h", $time, a, e);
            end
        end
    end

    function automatic logic [24:0] pack_s();
        return {vs.hsync, vs.vsync, vs.active, vs.x, vs.y, vs.line_start, vs.frame_start};
    endfunction
    function automatic logic [24:0] pack_d();
        return {vd.hsync, vd.vsync, vd.active, vd.x, vd.y, vd.line_start, vd.frame_start};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 1'b1;
        #1;
        n_vec++;
        if (pack_s() !== 25'd0) begin
            n_err++; $display("FAIL reset_async_small got=%h expected=0", pack_s());
        end
        repeat (4) @(posedge px_clk);
        #1;
        n_vec++;
        if (pack_s() !== 25'd0) begin
            n_err++; $display("FAIL reset_hold_small got=%h expected=0", pack_s());
        end
        n_vec++;
        if (pack_d() !== 25'd0) begin
            n_err++; $display("FAIL reset_hold_default got=%h expected=0", pack_d());
        end
    endtask

    task automatic test_startup();
        @(negedge px_clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge px_clk);
        #1;
        n_vec++;
        if (pack_s() !== 25'd0) begin
            n_err++; $display("FAIL startup_edge3 got=%h expected=0", pack_s());
        end
        @(posedge px_clk);
        #1;
        n_vec++;
        if (!(vs.frame_start === 1'b1 && vs.line_start === 1'b1 && vs.x === 11'd0 &&
              vs.y === 10'd0 && vs.active === 1'b1 && vs.hsync === 1'b0)) begin
            n_err++; $display("FAIL startup_edge4_small got=%h expected fs=1 x=0 y=0", pack_s());
        end
        n_vec++;
        if (!(vd.frame_start === 1'b1 && vd.x === 11'd0 && vd.y === 10'd0)) begin
            n_err++; $display("FAIL startup_edge4_default got=%h expected fs=1 x=0 y=0", pack_d());
        end
    endtask

    task automatic test_steady_small();
        int act_n = 0, hs_n = 0, vs_n = 0, ls_n = 0, fs_n = 0;
        int max_x = 0, max_y = 0, last_fs = -1, bad_period = 0;
        int vs_x = -1, vs_y = -1;
        logic vs_prev = 1'b0;
        for (int i = 0; i < 3 * SHT * SVT; i++) begin
            @(negedge px_clk);
            act_n += int'(vs.active);
            hs_n  += int'(vs.hsync);
            vs_n  += int'(vs.vsync);
            ls_n  += int'(vs.line_start);
            if (vs.frame_start) begin
                fs_n++;
                if (last_fs >= 0 && i - last_fs != SHT * SVT) bad_period++;
                last_fs = i;
            end
            if (vs.vsync && !vs_prev && vs_x < 0) begin
                vs_x = int'(vs.x); vs_y = int'(vs.y);
            end
            vs_prev = vs.vsync;
            if (int'(vs.x) > max_x) max_x = int'(vs.x);
            if (int'(vs.y) > max_y) max_y = int'(vs.y);
        end
        n_vec++;
        if (act_n != 3 * SHV * SVV) begin
            n_err++; $display("FAIL steady_active_count got=%0d expected=%0d", act_n, 3 * SHV * SVV);
        end
        n_vec++;
        if (hs_n != 3 * SHS * SVT) begin
            n_err++; $display("FAIL steady_hsync_count got=%0d expected=%0d", hs_n, 3 * SHS * SVT);
        end
        n_vec++;
        if (vs_n != 3 * SVS * SHT) begin
            n_err++; $display("FAIL steady_vsync_count got=%0d expected=%0d", vs_n, 3 * SVS * SHT);
        end
        n_vec++;
        if (ls_n != 3 * SVT || fs_n != 3 || bad_period != 0) begin
            n_err++; $display("FAIL steady_strobes ls=%0d fs=%0d badper=%0d expected ls=%0d fs=3 badper=0",
                              ls_n, fs_n, bad_period, 3 * SVT);
        end
        n_vec++;
        if (max_x != SHT - 1 || max_y != SVT - 1) begin
            n_err++; $display("FAIL steady_max_xy got=%0d/%0d expected=%0d/%0d", max_x, max_y, SHT - 1, SVT - 1);
        end
        n_vec++;
        if (vs_x != 0 || vs_y != SVV + SVF) begin
            n_err++; $display("FAIL steady_vsync_start got=%0d/%0d expected=0/%0d", vs_x, vs_y, SVV + SVF);
        end
    endtask

    task automatic test_default_line();
        int k = 0;
        int act_n = 0, hs_n = 0, ls_n = 0, vs_n = 0, hs_first = -1, hs_last = -1;
        logic [9:0] yl;
        while (!vd.line_start && k < DHT + 10) begin
            @(negedge px_clk);
            k++;
        end
        n_vec++;
        if (!vd.line_start) begin
            n_err++; $display("FAIL default_line_wait timeout got=0 expected line_start=1");
            return;
        end
        yl = vd.y;
        for (int i = 0; i < DHT; i++) begin
            if (i > 0) @(negedge px_clk);
            act_n += int'(vd.active);
            ls_n  += int'(vd.line_start);
            vs_n  += int'(vd.vsync);
            if (vd.hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(vd.x);
                hs_last = int'(vd.x);
            end
        end
        n_vec++;
        if (act_n != DHV || ls_n != 1 || vs_n != 0 || yl !== 10'd1) begin
            n_err++; $display("FAIL default_line act=%0d ls=%0d vs=%0d y=%0d expected 800/1/0/1",
                              act_n, ls_n, vs_n, yl);
        end
        n_vec++;
        if (hs_n != DHS || hs_first != DHV + DHF || hs_last != DHV + DHF + DHS - 1) begin
            n_err++; $display("FAIL default_hsync cnt=%0d first=%0d last=%0d expected 120/856/975",
                              hs_n, hs_first, hs_last);
        end
    endtask

    task automatic test_lock_drop();
        int k = 0;
        while (!(vs.y === 10'd2 && vs.x === 11'd3) && k < 2 * SHT * SVT) begin
            @(negedge px_clk);
            k++;
        end
        n_vec++;
        if (!(vs.y === 10'd2 && vs.x === 11'd3)) begin
            n_err++; $display("FAIL lock_drop_wait got=%0d/%0d expected 3/2", vs.x, vs.y);
        end
        #2 pll_locked = 1'b0;
        k = 0;
        do begin
            @(posedge px_clk);
            #1;
            k++;
        end while ((pack_s() !== 25'd0 || pack_d() !== 25'd0) && k < 8);
        n_vec++;
        if (k > 4 || pack_s() !== 25'd0 || pack_d() !== 25'd0) begin
            n_err++; $display("FAIL lock_drop_inactive edges=%0d expected<=4 outs=%h", k, pack_s());
        end
        repeat (5) @(negedge px_clk);
        #2 pll_locked = 1'b1;
        k = 0;
        do begin
            @(posedge px_clk);
            #1;
            k++;
        end while (vs.frame_start !== 1'b1 && k < 8);
        n_vec++;
        if (k != 4 || vs.x !== 11'd0 || vs.y !== 10'd0 || vd.frame_start !== 1'b1) begin
            n_err++; $display("FAIL relock_restart edges=%0d x=%0d y=%0d dfs=%b expected 4/0/0/1",
                              k, vs.x, vs.y, vd.frame_start);
        end
    endtask

    task automatic test_reset_midline();
        int k = 0;
        while (vd.x !== 11'd500 && k < DHT) begin
            @(negedge px_clk);
            k++;
        end
        n_vec++;
        if (vd.x !== 11'd500 || vd.active !== 1'b1) begin
            n_err++; $display("FAIL midline_wait x=%0d act=%b expected 500/1", vd.x, vd.active);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pack_d() !== 25'd0 || pack_s() !== 25'd0) begin
            n_err++; $display("FAIL midline_reset_async got=%h/%h expected=0/0", pack_d(), pack_s());
        end
        repeat (3) @(negedge px_clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge px_clk);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_steady_small();
        test_default_line();
        test_lock_drop();
        test_reset_midline();
        @(posedge px_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
